// File: rtl/pause_pkg.sv
// Shared state encoding and default timing for the pause controller.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SYNC    = 2'd1,
        PAUSED  = 2'd2,
        RELEASE = 2'd3
    } pause_state_t;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_SYNC_TIMEOUT = 500000;     // cycles to wait for vblank
    localparam int DEF_DIM_CYCLES   = 120000000;  // 10 s at 12 MHz

    // The CPU stays halted while a pause is held or is being released.
    function automatic logic is_halted(input pause_state_t s);
        return (s == PAUSED) || (s == RELEASE);
    endfunction

endpackage

// File: rtl/pause_prio_arb.sv
// Fixed-priority (bit 0 wins), non-preemptive one-hot grant for pause requesters.
// Latency: grant registered, updates on the edge after req/enable change.
// Backpressure: none; an owner keeps its grant until its req drops, then one idle cycle.
module pause_prio_arb
    import pause_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] grant_d;
    logic [NREQ-1:0] pick;

    // Lowest-index active request, one-hot.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // Hold the owner while its req stays up; a drop forces one empty cycle before re-arbitration.
    always_comb begin
        grant_d = '0;
        if (enable) begin
            if (grant_q != '0) begin
                grant_d = ((grant_q & req) != '0) ? grant_q : '0;
            end else begin
                grant_d = pick;
            end
        end
    end

    // Grant register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/pause_ctrl.sv
// Pause controller: merges requesters and a user toggle, aligns pause entry/exit to vblank.
// Latency: state, pause_cpu and grant registered; cpu_reset masks pause_cpu combinationally.
// Backpressure: none; vblank waits bounded by SYNC_TIMEOUT. Optional dimming under PAUSE_DIM_EN.
module pause_ctrl
    import pause_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int DIM_CYCLES   = DEF_DIM_CYCLES
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            cpu_reset,
    input  logic            user_button,
    input  logic [NREQ-1:0] req,
    input  logic            vblank,
    input  logic            dim_option,
    output logic            pause_cpu,
    output logic [NREQ-1:0] grant,
`ifdef PAUSE_DIM_EN
    output logic            dim_video,
`endif
    output logic [1:0]      state_o
);

    localparam logic [31:0] WAIT_MAX = 32'(SYNC_TIMEOUT - 1);

    pause_state_t state_q, state_d;
    logic [31:0]  wait_q, wait_d;
    logic         toggle_q, toggle_d;
    logic         pause_q, pause_d;
    logic         btn_q, vbl_q;
    logic         btn_rise, vbl_rise, any_src, timeout, arb_en;

    assign btn_rise = user_button & ~btn_q;
    assign vbl_rise = vblank & ~vbl_q;
    assign any_src  = (|req) | toggle_q;
    assign timeout  = (wait_q == WAIT_MAX);

    // Next state, wait counter, halt flag and user toggle.
    always_comb begin
        state_d  = state_q;
        toggle_d = cpu_reset ? 1'b0 : (toggle_q ^ btn_rise);
        case (state_q)
            RUN:     if (any_src) state_d = SYNC;
            SYNC:    if (!any_src) state_d = RUN;
                     else if (vbl_rise || timeout) state_d = PAUSED;
            PAUSED:  if (!any_src) state_d = RELEASE;
            RELEASE: if (any_src) state_d = PAUSED;
                     else if (vbl_rise || timeout) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (cpu_reset) begin
            state_d = RUN;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end else begin
            wait_d = timeout ? wait_q : wait_q + 32'd1;
        end
        pause_d = is_halted(state_d);
        arb_en  = (state_d == PAUSED);
    end

    // Control state and edge-detect history.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            wait_q   <= '0;
            toggle_q <= 1'b0;
            pause_q  <= 1'b0;
            btn_q    <= 1'b0;
            vbl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            toggle_q <= toggle_d;
            pause_q  <= pause_d;
            btn_q    <= user_button;
            vbl_q    <= vblank;
        end
    end

    pause_prio_arb #(.NREQ(NREQ)) u_arb (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req     (req),
        .enable  (arb_en),
        .grant   (grant)
    );

    assign pause_cpu = pause_q & ~cpu_reset;
    assign state_o   = state_q;

`ifdef PAUSE_DIM_EN
    localparam logic [31:0] DIM_MAX = 32'(DIM_CYCLES);

    logic [31:0] dim_q, dim_d;

    // Count paused cycles with dimming enabled; any break restarts the count.
    always_comb begin
        dim_d = '0;
        if (pause_cpu && dim_option) begin
            dim_d = (dim_q == DIM_MAX) ? dim_q : dim_q + 32'd1;
        end
    end

    // Dim counter register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dim_q <= '0;
        end else begin
            dim_q <= dim_d;
        end
    end

    assign dim_video = (dim_q == DIM_MAX);
`else
    logic dim_option_unused;
    assign dim_option_unused = dim_option;
`endif

endmodule

// File: doc/pause_ctrl.md
PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- NREQ, 4, number of arbitrated pause requesters.
- SYNC_TIMEOUT, 500000, max cycles to wait for vblank before forcing the transition.
- DIM_CYCLES, 120000000, paused cycles before dim_video asserts (10 s at 12 MHz).
REQ-002 Ports SHALL be, one per line:
- clk_sys  in  1  core system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_reset  in  1  synchronous active-high core reset; clears the user pause.
- user_button  in  1  user pause button (active-high).
- req  in  NREQ  level pause requests; bit 0 is highest priority.
- vblank  in  1  video vertical blank, synchronous to clk_sys.
- dim_option  in  1  OSD dim-enable option (active-high).
- pause_cpu  out  1  CPU halt.
- grant  out  NREQ  one-hot exclusive-access grant.
- state_o  out  2  current FSM state, for debug.
- dim_video  out  1  dim request; present only with PAUSE_DIM_EN.

Function
REQ-003 The block SHALL contain a user toggle: each rising edge of user_button inverts it; cpu_reset high forces it to 0, overriding a simultaneous edge.
REQ-004 The block SHALL compute any_src = |req | toggle.
REQ-005 FSM states SHALL be RUN=0, SYNC=1, PAUSED=2, RELEASE=3, all registered.
REQ-006 RUN SHALL go to SYNC when any_src=1.
REQ-007 SYNC SHALL go to PAUSED on a vblank rising edge or when the wait counter reaches SYNC_TIMEOUT-1; SYNC SHALL go to RUN if any_src drops first.
REQ-008 PAUSED SHALL go to RELEASE when any_src=0.
REQ-009 RELEASE SHALL go to RUN on a vblank rising edge or on timeout; RELEASE SHALL go back to PAUSED if any_src reasserts, and that check takes priority over vblank.
REQ-010 The wait counter SHALL clear on every state change and saturate at SYNC_TIMEOUT-1.
REQ-011 pause_cpu SHALL be 1 exactly in PAUSED and RELEASE, registered, asserting on the same edge that enters PAUSED.
REQ-012 grant SHALL be nonzero only in PAUSED.
REQ-013 Arbitration SHALL be fixed priority among req bits: the lowest index active bit wins.
REQ-014 Grants SHALL be non-preemptive: the owner keeps its grant until its req drops.
REQ-015 After the owner drops, grant SHALL go to 0 for one cycle, then go to the next winner.
REQ-016 The toggle SHALL hold the pause but SHALL never receive a grant.
REQ-017 Leaving PAUSED SHALL clear grant on the same edge.
REQ-018 When cpu_reset=1, pause_cpu SHALL be forced to 0 combinationally, and the FSM SHALL go to RUN on the next edge.
REQ-019 vblank edge detection SHALL use a one-cycle registered history; vblank already high on entering SYNC SHALL NOT count as an edge.

Reset
REQ-020 While reset_n=0, the block SHALL force state RUN, toggle 0, counters 0, pause_cpu 0, grant 0 and dim_video 0.
REQ-021 The vblank and button history registers SHALL reset to 0.
REQ-022 Reset SHALL take effect immediately, asynchronously.
REQ-023 Release of reset_n SHALL be assumed synchronised externally.

Configuration
REQ-024 The macro PAUSE_DIM_EN SHALL control the dim feature.
REQ-025 With PAUSE_DIM_EN defined, a 32-bit dim counter SHALL increment while pause_cpu=1 and dim_option=1, saturating at DIM_CYCLES.
REQ-026 With PAUSE_DIM_EN defined, dim_video SHALL be 1 when the counter equals DIM_CYCLES; the counter SHALL clear otherwise.
REQ-027 Without PAUSE_DIM_EN, the dim_video port and the dim counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package pause_pkg SHALL hold the state encoding constants (RUN, SYNC, PAUSED, RELEASE) and the default timing constants.
REQ-029 Sub-module pause_prio_arb SHALL implement the fixed-priority, non-preemptive one-hot arbiter: inputs req, enable; output grant.

Verification (NREQ=4, SYNC_TIMEOUT=16, DIM_CYCLES=32)
REQ-030 Entry test: req=0010 in RUN, vblank rise 5 cycles later -> SYNC for 5 cycles, then PAUSED with pause_cpu=1 and grant=0010 on the same edge.
REQ-031 Non-preemption test: owner bit1 holds, req=0011 -> grant stays 0010; drop bit1 -> grant 0000 for one cycle, then 0001.
REQ-032 Sync timeout test: no vblank in SYNC -> PAUSED after exactly 16 cycles; same in RELEASE -> RUN after 16 cycles.
REQ-033 Re-entry and reset test: user_button pulse in RUN -> pause with grant=0000; req bit0 reasserts in RELEASE -> PAUSED, grant 0001; cpu_reset pulse -> toggle 0 and pause_cpu 0 immediately, RUN next edge.
REQ-034 Dim test (PAUSE_DIM_EN defined): paused with dim_option=1 -> dim_video=1 after 32 cycles and stays 1; dim_option low -> dim_video 0 next cycle.
REQ-035 Async reset test: reset_n pulled low mid-PAUSED between clock edges -> all outputs 0 without waiting for an edge.
